// File: rtl/instr_sequencer.sv
// Instruction recorder/player: stores up to DEPTH {torque,dir} entries and plays them back,
// one step per STEP_CYCLES clocks. Define SEQ_LOOP_EN to add the 'loop' input for continuous replay.
module instr_sequencer #(
    parameter int DEPTH       = 16,
    parameter int DIR_W       = 2,
    parameter int TORQUE_W    = 2,
    parameter int STEP_CYCLES = 50_000_000
) (
    input  logic                            CLOCK_50,
    input  logic                            rst,
    input  logic                            save,
    input  logic                            delete,
    input  logic                            execute,
    input  logic                            clear,
`ifdef SEQ_LOOP_EN
    input  logic                            loop,
`endif
    input  logic [DIR_W+TORQUE_W-1:0]       instr_in,
    output logic [DIR_W-1:0]                dir_out,
    output logic [TORQUE_W-1:0]             torque_out,
    output logic                            motion_valid,
    output logic [$clog2(DEPTH)-1:0]        step_idx,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            full,
    output logic                            empty,
    output logic                            done
);

    localparam int IW    = DIR_W + TORQUE_W;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t               r_state, w_state_nxt;
    logic [IW-1:0]        r_mem [DEPTH];
    logic [CNT_W-1:0]     r_count, w_count_nxt;
    logic [IDX_W-1:0]     r_step_idx, w_step_nxt;
    logic [TMR_W-1:0]     r_timer, w_timer_nxt;
    logic [DIR_W-1:0]     r_dir, w_dir_nxt;
    logic [TORQUE_W-1:0]  r_torque, w_torque_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_full, r_empty;
    logic                 w_mem_we;
    logic                 w_tc;
    logic                 w_last;
    logic                 w_loop;
    logic [IDX_W-1:0]     w_rd_idx;
    logic [IW-1:0]        w_rd_data;

`ifdef SEQ_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    assign w_tc   = (r_timer == TMR_W'(STEP_CYCLES - 1));
    assign w_last = ((CNT_W'(r_step_idx) + CNT_W'(1)) == r_count);

    // The read port serves both the execute load (entry 0) and step advance,
    // so it is driven outside the next-state block to keep the comb graph acyclic.
    assign w_rd_idx  = (r_state == S_RUN && !w_last) ? r_step_idx + IDX_W'(1) : '0;
    assign w_rd_data = r_mem[w_rd_idx];

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_step_nxt   = r_step_idx;
        w_timer_nxt  = r_timer;
        w_dir_nxt    = r_dir;
        w_torque_nxt = r_torque;
        w_valid_nxt  = r_valid;
        w_done_nxt   = 1'b0;
        w_mem_we     = 1'b0;

        if (clear) begin
            w_state_nxt  = S_IDLE;
            w_count_nxt  = '0;
            w_step_nxt   = '0;
            w_timer_nxt  = '0;
            w_dir_nxt    = '0;
            w_torque_nxt = '0;
            w_valid_nxt  = 1'b0;
        end else if (r_state == S_IDLE) begin
            // Only the highest-priority pulse is considered, even if it is then ignored.
            if (execute) begin
                if (!r_empty) begin
                    w_state_nxt  = S_RUN;
                    w_step_nxt   = '0;
                    w_timer_nxt  = '0;
                    w_dir_nxt    = w_rd_data[DIR_W-1:0];
                    w_torque_nxt = w_rd_data[IW-1:DIR_W];
                    w_valid_nxt  = 1'b1;
                end
            end else if (delete) begin
                if (!r_empty) w_count_nxt = r_count - CNT_W'(1);
            end else if (save) begin
                if (!r_full) begin
                    w_mem_we    = 1'b1;
                    w_count_nxt = r_count + CNT_W'(1);
                end
            end
        end else begin
            if (!w_tc) begin
                w_timer_nxt = r_timer + TMR_W'(1);
            end else begin
                w_timer_nxt = '0;
                if (!w_last || w_loop) begin
                    w_step_nxt   = w_rd_idx;
                    w_dir_nxt    = w_rd_data[DIR_W-1:0];
                    w_torque_nxt = w_rd_data[IW-1:DIR_W];
                end else begin
                    w_state_nxt  = S_IDLE;
                    w_step_nxt   = '0;
                    w_dir_nxt    = '0;
                    w_torque_nxt = '0;
                    w_valid_nxt  = 1'b0;
                    w_done_nxt   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_step_idx <= '0;
            r_timer    <= '0;
            r_dir      <= '0;
            r_torque   <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
        end else begin
            r_count    <= w_count_nxt;
            r_step_idx <= w_step_nxt;
            r_timer    <= w_timer_nxt;
            r_dir      <= w_dir_nxt;
            r_torque   <= w_torque_nxt;
            r_valid    <= w_valid_nxt;
            r_done     <= w_done_nxt;
            r_full     <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty    <= (w_count_nxt == '0);
        end
    end

    // Program storage carries no reset; only entries below count are ever read.
    always_ff @(posedge CLOCK_50) begin
        if (w_mem_we) r_mem[r_count[IDX_W-1:0]] <= instr_in;
    end

    assign dir_out      = r_dir;
    assign torque_out   = r_torque;
    assign motion_valid = r_valid;
    assign step_idx     = r_step_idx;
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign done         = r_done;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Parametrised instruction recorder/player for the robot drive path. Stores up to DEPTH direction+torque instructions entered by the user, supports undo of the last entry and clearing of the whole program, and plays the program back one step per STEP_CYCLES clock cycles. It sits between the debounced/edge-detected key logic and the motor/HEX/LED display decode, and is the generalised successor of the fixed-size recorder in top_level.

Parameters:
DEPTH, 16, maximum stored instructions (>=2)
DIR_W, 2, direction field width (0=forward,1=reverse,2=left,3=right for DIR_W=2)
TORQUE_W, 2, torque level field width
STEP_CYCLES, 50_000_000, clock cycles each instruction is held during playback (1 s at 50 MHz, >=1)

Ports:
CLOCK_50  in  1  system clock
rst  in  1  asynchronous active-high reset
save  in  1  single-cycle pulse: append instr_in
delete  in  1  single-cycle pulse: remove most recently saved entry
execute  in  1  single-cycle pulse: start playback
clear  in  1  single-cycle pulse: empty program, abort playback
instr_in  in  DIR_W+TORQUE_W  {torque, direction} to store; direction in LSBs
dir_out  out  DIR_W  direction of current playback step
torque_out  out  TORQUE_W  torque of current playback step
motion_valid  out  1  high while a step is being played
step_idx  out  $clog2(DEPTH)  index of current step (0 when idle)
count  out  $clog2(DEPTH+1)  number of stored instructions
full  out  1  count==DEPTH
empty  out  1  count==0
done  out  1  one-cycle pulse after last step completes

Behaviour:
- Reset (async, active-high): state IDLE, count=0, step_idx=0, dir_out=0, torque_out=0, motion_valid=0, done=0, empty=1, full=0. Memory contents don't-care.
- States: IDLE, RUN. All outputs registered.
- Priority when several inputs pulse in the same cycle: clear > execute > delete > save. Only the highest-priority one takes effect.
- IDLE, save and not full: mem[count]<=instr_in, count+1 next cycle. Save when full: ignored, no wrap, count unchanged.
- IDLE, delete and not empty: count-1 (LIFO undo). Delete when empty: ignored.
- IDLE, execute and count>0: next cycle RUN, step_idx=0, dir_out/torque_out=mem[0], motion_valid=1, step timer=0. Execute when empty: ignored, stays IDLE, no done.
- RUN: timer counts 0..STEP_CYCLES-1. Each step's outputs hold exactly STEP_CYCLES cycles. At terminal count with step_idx<count-1: step_idx+1, outputs load next entry on the following cycle (no gap). At terminal count of the last step: next cycle IDLE, motion_valid=0, dir_out=0, torque_out=0, step_idx=0, done=1 for exactly one cycle.
- RUN: save, delete and execute are ignored (no restart, no buffer change).
- clear in any state: next cycle IDLE, count=0, outputs zeroed, motion_valid=0, no done pulse.
- Program is retained after playback; execute replays it unchanged.
- Timer width $clog2(STEP_CYCLES) (min 1). No other arithmetic overflow is possible since count is bounded by guards.
- rst asserted mid-playback: immediate return to reset values regardless of clock.

Optional Feature:
SEQ_LOOP_EN: when defined, adds input port loop (1 bit). In RUN, at the terminal count of the last step with loop=1, playback wraps to step_idx=0, loading mem[0] on the next cycle without leaving RUN or pulsing done. loop=0 behaves as base design. Only clear or rst exits continuous looping. When undefined, the port is absent and playback always ends after the last step.

Test Plan:
- Reset then 4 saves of {torque,dir}=0x0,0x4,0x8,0xE -> count=4, empty=0, full=0. Execute (STEP_CYCLES=4) -> dir/torque sequences 0/0,0/1,0/2,2/3, each held exactly 4 cycles. done pulses 1 cycle later, outputs return to 0.
- DEPTH=4: 5 saves -> count=4, full=1, 5th value absent in playback. Delete then save 0x3 -> last step plays dir=3, torque=0.
- Execute with count=0 -> remains IDLE, motion_valid=0, done never asserts. Delete with count=0 -> count stays 0.
- During RUN pulse save and execute -> count unchanged, step timing unchanged. Then pulse clear at step 2 -> next cycle motion_valid=0, count=0, no done.
- Same-cycle save+delete with count=2 -> count=1. Same-cycle execute+clear -> IDLE, count=0. Assert rst mid-step asynchronously -> all outputs reset before next clock edge.
- With SEQ_LOOP_EN and loop=1, 2-entry program -> steps 0,1,0,1,... with no done. Drop loop to 0 -> finishes at end of current pass, done pulses once.
